seg_scan_ctrl: RTL and testbench

Sequencing controller for the parking-lot free-space display. It accepts a binary count over a valid/ready handshake and converts it to BCD with an iterative shift-add-3 engine. It then time-multiplexes the digits onto one shared seven_segment decoder, driving the decoder's 4-bit nibble input and the active-low digit anodes. It sits between the occupancy counter and the seven_segment decoder.

---
 rtl/seg_scan_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Count-to-BCD converter with a multiplexed seven-segment digit scanner.
// Optional build macro LEADING_ZERO_BLANK_EN turns off the anodes of leading zero digits.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS = 2,
    parameter int CNT_W      = 7,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CNT_W-1:0]      value_in,
    input  logic                  value_valid,
    output logic                  value_ready,
    input  logic                  disp_on,
    output logic [3:0]            digit_bcd,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  busy,
    output logic                  sat
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int BIT_W = $clog2(CNT_W + 1);

    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    localparam int MAX_VAL = pow10(NUM_DIGITS) - 1;

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        op_q, op_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d, bcd_adj;
    logic [BIT_W-1:0]        cnt_q, cnt_d;
    logic                    psat_q, psat_d;
    logic                    sat_q, sat_d;
    logic [BCD_W-1:0]        disp_q, disp_d;
    logic [PRE_W-1:0]        pre_q, pre_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [3:0]              digit_bcd_q, digit_bcd_d;
    logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
    logic                    blank;
    logic                    xfer;

    assign xfer = value_valid && (state_q == IDLE);

    // FSM: state register
    // NOTE: sequential state uses non-blocking (<=) so all flops update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    // NOTE: every comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (value_valid) state_d = CONVERT;
            CONVERT: if (cnt_q == BIT_W'(1)) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        value_ready = 1'b0;
        busy        = 1'b0;
        unique case (state_q)
            IDLE:    value_ready = 1'b1;
            CONVERT: busy = 1'b1;
            COMMIT:  busy = 1'b1;
            default: value_ready = 1'b0;
        endcase
    end

    // Shift-add-3: nibbles of 5 or more overflow past 9 once doubled, so pre-correct them.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        op_d   = op_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        psat_d = psat_q;
        sat_d  = sat_q;
        disp_d = disp_q;
        if (xfer) begin
            if (int'(value_in) > MAX_VAL) begin
                op_d   = CNT_W'(MAX_VAL);
                psat_d = 1'b1;
            end else begin
                op_d   = value_in;
                psat_d = 1'b0;
            end
            bcd_d = '0;
            cnt_d = BIT_W'(CNT_W);
        end else if (state_q == CONVERT) begin
            bcd_d = {bcd_adj[BCD_W-2:0], op_q[CNT_W-1]};
            op_d  = op_q << 1;
            cnt_d = cnt_q - BIT_W'(1);
        end else if (state_q == COMMIT) begin
            disp_d = bcd_q;
            sat_d  = psat_q;
        end
    end

    // Scanner runs regardless of the converter.
    always_comb begin
        pre_d = pre_q + PRE_W'(1);
        idx_d = idx_q;
        if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Walking down from the MSD, a slot is blank while every digit at or above it is zero.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        blank      = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (disp_q[4*i +: 4] != 4'd0) upper_zero = 1'b0;
            if ((int'(idx_q) == i) && upper_zero) blank = 1'b1;
        end
    end
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        digit_bcd_d = disp_q[4*int'(idx_q) +: 4];
        if (!disp_on || blank) digit_en_d = {NUM_DIGITS{1'b1}};
        else                   digit_en_d = ~(NUM_DIGITS'(1) << idx_q);
    end

    // The display bank is only a few nibbles, so it is reset with the rest of the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            psat_q      <= 1'b0;
            sat_q       <= 1'b0;
            disp_q      <= '0;
            pre_q       <= '0;
            idx_q       <= '0;
            digit_bcd_q <= '0;
            digit_en_q  <= {NUM_DIGITS{1'b1}};
        end else begin
            op_q        <= op_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            psat_q      <= psat_d;
            sat_q       <= sat_d;
            disp_q      <= disp_d;
            pre_q       <= pre_d;
            idx_q       <= idx_d;
            digit_bcd_q <= digit_bcd_d;
            digit_en_q  <= digit_en_d;
        end
    end

    assign digit_bcd = digit_bcd_q;
    assign digit_en  = digit_en_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=2, CNT_W=7, SCAN_DIV=4.
// Honours LEADING_ZERO_BLANK_EN when the bundle is built with it.
module tb_seg_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] value_in = '0;
    logic       value_valid = 1'b0;
    logic       value_ready;
    logic       disp_on = 1'b1;
    logic [3:0] digit_bcd;
    logic [1:0] digit_en;
    logic       busy;
    logic       sat;

    int checks = 0;
    int failures = 0;
    int edge_cnt = 0;

    seg_scan_ctrl #(.NUM_DIGITS(2), .CNT_W(7), .SCAN_DIV(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value_in    (value_in),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .disp_on     (disp_on),
        .digit_bcd   (digit_bcd),
        .digit_en    (digit_en),
        .busy        (busy),
        .sat         (sat)
    );

    always #5 clk = ~clk;

    // Edges since reset release; slot driven after edge k is ((k-1)/4) mod 2.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    function automatic logic [1:0] exp_en0(input logic on);
        return on ? 2'b10 : 2'b11;
    endfunction

    function automatic logic [1:0] exp_en1(input logic [3:0] tens, input logic on);
        if (!on) return 2'b11;
`ifdef LEADING_ZERO_BLANK_EN
        if (tens == 4'd0) return 2'b11;
`endif
        return 2'b01;
    endfunction

    // Watch one full scan period and report what each slot showed.
    task automatic capture(input logic [1:0] ee0, input logic [1:0] ee1,
                           output logic [3:0] c0, output logic [3:0] c1, output int en_bad);
        int slot;
        c0 = 4'hx;
        c1 = 4'hx;
        en_bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            slot = ((edge_cnt - 1) / 4) % 2;
            if (slot == 0) begin
                c0 = digit_bcd;
                if (digit_en !== ee0) en_bad++;
            end else begin
                c1 = digit_bcd;
                if (digit_en !== ee1) en_bad++;
            end
        end
    endtask

    task automatic send(input logic [6:0] v);
        int n;
        @(negedge clk);
        value_in = v;
        value_valid = 1'b1;
        n = 0;
        while (value_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (value_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_timeout value=%0d ready=%b required=1", v, value_ready);
        end
        @(negedge clk);
        value_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_timeout busy=%b required=0", busy);
        end
        @(negedge clk);
    endtask

    task automatic check_display(input string name, input logic [3:0] e1, input logic [3:0] e0);
        logic [3:0] c0, c1;
        int en_bad;
        capture(exp_en0(disp_on), exp_en1(e1, disp_on), c0, c1, en_bad);
        checks++;
        if (c0 !== e0 || c1 !== e1) begin
            failures++;
            $display("FAIL %s_digits got=%h%h required=%h%h", name, c1, c0, e1, e0);
        end
        checks++;
        if (en_bad != 0) begin
            failures++;
            $display("FAIL %s_anodes bad_cycles=%0d required=0", name, en_bad);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({value_ready, busy, sat, digit_en, digit_bcd} !== {1'b1, 1'b0, 1'b0, 2'b11, 4'h0}) begin
            failures++;
            $display("FAIL reset_outputs got=%b%b%b %b %h required=100 11 0",
                     value_ready, busy, sat, digit_en, digit_bcd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_display("reset_scan", 4'd0, 4'd0);
        checks++;
        if (value_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got=%b required=1", value_ready);
        end
    endtask

    task automatic test_convert();
        int busy_cycles;
        send(7'd37);
        busy_cycles = 0;
        while (busy === 1'b1 && busy_cycles < 50) begin
            busy_cycles++;
            @(negedge clk);
        end
        checks++;
        if (busy_cycles != 8) begin
            failures++;
            $display("FAIL convert_busy_len got=%0d required=8", busy_cycles);
        end
        @(negedge clk);
        check_display("convert_37", 4'd3, 4'd7);
        checks++;
        if (sat !== 1'b0) begin
            failures++;
            $display("FAIL convert_sat got=%b required=0", sat);
        end
    endtask

    task automatic test_saturate();
        send(7'd120);
        wait_idle();
        check_display("sat_99", 4'd9, 4'd9);
        checks++;
        if (sat !== 1'b1) begin
            failures++;
            $display("FAIL sat_flag got=%b required=1", sat);
        end
        send(7'd5);
        wait_idle();
        check_display("sat_05", 4'd0, 4'd5);
        checks++;
        if (sat !== 1'b0) begin
            failures++;
            $display("FAIL sat_clear got=%b required=0", sat);
        end
    endtask

    task automatic test_back_to_back();
        int low_cycles;
        send(7'd61);
        value_in = 7'd42;
        value_valid = 1'b1;
        low_cycles = 0;
        while (value_ready !== 1'b1 && low_cycles < 50) begin
            low_cycles++;
            @(negedge clk);
        end
        checks++;
        if (low_cycles != 8) begin
            failures++;
            $display("FAIL b2b_ready_low got=%0d required=8", low_cycles);
        end
        @(negedge clk);
        value_valid = 1'b0;
        check_display("b2b_first_61", 4'd6, 4'd1);
        wait_idle();
        check_display("b2b_then_42", 4'd4, 4'd2);
    endtask

    task automatic test_reset_mid_convert();
        send(7'd88);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({value_ready, busy, sat, digit_en, digit_bcd} !== {1'b1, 1'b0, 1'b0, 2'b11, 4'h0}) begin
            failures++;
            $display("FAIL abort_outputs got=%b%b%b %b %h required=100 11 0",
                     value_ready, busy, sat, digit_en, digit_bcd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_display("abort_00", 4'd0, 4'd0);
        send(7'd64);
        wait_idle();
        check_display("abort_then_64", 4'd6, 4'd4);
    endtask

    task automatic test_disp_off();
        send(7'd56);
        wait_idle();
        disp_on = 1'b0;
        check_display("off_56", 4'd5, 4'd6);
        disp_on = 1'b1;
        send(7'd5);
        wait_idle();
        check_display("on_05", 4'd0, 4'd5);
    endtask

    initial begin
        test_reset();
        test_convert();
        test_saturate();
        test_back_to_back();
        test_reset_mid_convert();
        test_disp_off();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout time=%0t", $time);
        $fatal(1, "bench timed out");
    end

endmodule
